adc_cal_sequencer: RTL and testbench
====================================

# adc_cal_sequencer

Sequences the ADC calibration and DTU restart for the two-gain LiTE-DTU datapath. On a start command it resets the selected ADCs (gain 10 and gain 1), pulses each ADC's calibration input in turn and supervises its calibration-busy flag with timeouts. It then holds and releases the DTU reset and issues a one-cycle flush. It sits between the I2C/sync command logic and the ADC and DTU reset/calibration pins.

## Interface

Parameters:
- RST_CYCLES, 16: ADC reset and DTU post-calibration reset hold length, in clocks (≥1).
- CAL_PULSE, 4: width of each AdcCal pulse, in clocks (≥1).
- BUSY_WAIT, 64: maximum clocks allowed for the synchronized busy signal to rise after the pulse ends.
- BUSY_TIMEOUT, 4095: maximum clocks allowed for busy to fall once it has risen.
- CNT_W, 12: phase counter width; must hold the maximum of all of the above.

Ports:
- clock, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle request; sampled only in IDLE.
- abort, in, 1: returns the block to IDLE from any state.
- cal_mask, in, 2: bit0 = gain-1 ADC, bit1 = gain-10 ADC; sampled together with start.
- AdcCalBusy_in, in, 2: busy flags from the ADCs; each passes through a 2-flop synchronizer.
- AdcRst_b, out, 2: active-low ADC resets.
- AdcCal, out, 2: calibration pulses.
- DtuRst_b, out, 1: active-low DTU reset.
- DtuFlush, out, 1: one-cycle flush.
- seq_busy, out, 1: high while not in IDLE.
- done, out, 1: one-cycle pulse on success.
- error, out, 1: sticky; cleared by the next accepted start or by rst.
- err_code, out, 2: 00 none, 01 busy never rose, 10 busy stuck high.
- err_ch, out, 1: index of the failing channel.

## Operation

- Reset values: AdcRst_b=11, AdcCal=00, DtuRst_b=1, DtuFlush=0, seq_busy=0, done=0, error=0, err_code=00, err_ch=0. The state is IDLE, the counter is 0 and the synchronizers are cleared.
- All outputs are registered.
- States and transitions: IDLE → ADC_RST → (CAL_PULSE → WAIT_HI → WAIT_LO) per masked channel → DTU_HOLD → FLUSH → DONE → IDLE. An error path runs ERR → IDLE.
- IDLE:
  - start=1 latches cal_mask, clears error and err_code, and moves to ADC_RST.
- ADC_RST:
  - AdcRst_b[i]=0 for each masked i; DtuRst_b=0.
  - Lasts RST_CYCLES clocks.
  - Next state is CAL_PULSE for the lowest masked channel, or DTU_HOLD if the mask is 00.
- CAL_PULSE:
  - AdcCal[ch]=1 for CAL_PULSE clocks.
- WAIT_HI:
  - Synchronized busy[ch]=1 → WAIT_LO.
  - BUSY_WAIT clocks elapsed → ERR with code 01.
- WAIT_LO:
  - Synchronized busy[ch]=0 → next masked channel (CAL_PULSE), or DTU_HOLD when none remain.
  - BUSY_TIMEOUT clocks elapsed → ERR with code 10.
- DtuRst_b stays 0 from ADC_RST through DTU_HOLD.
- DTU_HOLD: lasts RST_CYCLES clocks.
- FLUSH: DtuRst_b=1, DtuFlush=1 for one clock.
- DONE: done=1 for one clock, then IDLE.
- ERR:
  - error=1 and err_code/err_ch are latched; AdcCal=00; DtuRst_b=1; no flush.
  - Next clock → IDLE.
- abort (checked before all other transitions, ignored in IDLE):
  - Next clock: state IDLE; AdcRst_b, AdcCal, DtuRst_b and DtuFlush return to reset values.
  - error is not set, and done is not pulsed.
- start while not in IDLE is ignored. start and abort together in IDLE: start wins.
- The counter loads param−1 on state entry and decrements to 0. The state exits on the clock where the count is 0, which gives exactly param cycles.

## Timing

- start at edge T: at T+1, seq_busy=1 and the reset outputs are low.
- ADC_RST spans T+1 … T+RST_CYCLES.
- AdcCal rises at T+RST_CYCLES+1, on the same edge where AdcRst_b is released.
- Busy latency: the synchronized busy lags AdcCalBusy_in by 2 clocks. The timeouts are counted on the synchronized signal.
- Mask 00: DtuRst_b is low for 2×RST_CYCLES clocks; done occurs at T+2×RST_CYCLES+2.
- rst asserted mid-sequence: all outputs take their reset values on the next edge, and there is no flush.

## Test plan

- Nominal run, RST_CYCLES=16, CAL_PULSE=4, mask=11, each busy high 100 clocks starting 5 clocks after its pulse:
  - AdcRst_b=00 for 16 clocks.
  - AdcCal[0] then AdcCal[1] pulses, 4 clocks each.
  - DtuRst_b released after DTU_HOLD, with DtuFlush and done as single pulses.
  - error=0.
- mask=10:
  - Only AdcRst_b[1] and AdcCal[1] toggle.
  - AdcCal[0] stays 0 throughout.
  - done=1.
- Busy[0] never rises:
  - ERR is reached 64 clocks after the WAIT_HI entry.
  - err_code=01, err_ch=0, error sticky, no DtuFlush, and channel 1 is never pulsed.
- Busy[1] stuck high:
  - err_code=10, err_ch=1 after 4095 clocks in WAIT_LO.
  - The next start clears error.
- abort during WAIT_LO:
  - Next clock: IDLE, seq_busy=0, DtuRst_b=1, AdcCal=00, error=0, done=0.
- start pulsed while seq_busy=1 has no effect. rst held 1 clock mid-CAL_PULSE sets all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/adc_cal_sequencer.sv
// ADC calibration and DTU restart sequencer for the two-gain LiTE-DTU datapath.
// Resets the selected ADCs, pulses each calibration input, supervises busy, then restarts the DTU.
module adc_cal_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int CAL_PULSE    = 4,
    parameter int BUSY_WAIT    = 64,
    parameter int BUSY_TIMEOUT = 4095,
    parameter int CNT_W        = 12
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] cal_mask,
    input  logic [1:0] AdcCalBusy_in,
    output logic [1:0] AdcRst_b,
    output logic [1:0] AdcCal,
    output logic       DtuRst_b,
    output logic       DtuFlush,
    output logic       seq_busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       err_ch
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADC_RST,
        S_CAL_PULSE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DTU_HOLD,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    // Phase lengths are loaded as N-1 so that the zero count marks the last cycle.
    localparam logic [CNT_W-1:0] C_RST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CAL  = CNT_W'(CAL_PULSE - 1);
    localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] C_TO   = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    localparam logic [1:0] CODE_NO_RISE = 2'b01;
    localparam logic [1:0] CODE_STUCK   = 2'b10;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mask;
    logic             r_ch;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;

    logic             w_busy;
    logic             w_cnt_zero;
    logic             w_has_next;
    logic             w_first_ch;
    logic [1:0]       w_first_cal;

    assign w_busy      = r_sync2[r_ch];
    assign w_cnt_zero  = (r_cnt == C_ZERO);
    assign w_has_next  = (r_ch == 1'b0) && r_mask[1];
    assign w_first_ch  = ~r_mask[0];
    assign w_first_cal = r_mask[0] ? 2'b01 : 2'b10;

    // Two-flop synchronizer for the asynchronous ADC busy flags.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= AdcCalBusy_in;
            r_sync2 <= r_sync1;
        end
    end

    // Sequencer state machine with all pin outputs registered.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= C_ZERO;
            r_mask   <= 2'b00;
            r_ch     <= 1'b0;
            AdcRst_b <= 2'b11;
            AdcCal   <= 2'b00;
            DtuRst_b <= 1'b1;
            DtuFlush <= 1'b0;
            seq_busy <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            err_ch   <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            // Abort drops the pins back to rest without flagging an error.
            r_state  <= S_IDLE;
            r_cnt    <= C_ZERO;
            AdcRst_b <= 2'b11;
            AdcCal   <= 2'b00;
            DtuRst_b <= 1'b1;
            DtuFlush <= 1'b0;
            seq_busy <= 1'b0;
            done     <= 1'b0;
        end else begin
            DtuFlush <= 1'b0;
            done     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask   <= cal_mask;
                        error    <= 1'b0;
                        err_code <= 2'b00;
                        err_ch   <= 1'b0;
                        AdcRst_b <= ~cal_mask;
                        DtuRst_b <= 1'b0;
                        seq_busy <= 1'b1;
                        r_cnt    <= C_RST;
                        r_state  <= S_ADC_RST;
                    end
                end
                S_ADC_RST: begin
                    if (w_cnt_zero) begin
                        AdcRst_b <= 2'b11;
                        if (r_mask == 2'b00) begin
                            r_cnt   <= C_RST;
                            r_state <= S_DTU_HOLD;
                        end else begin
                            r_ch    <= w_first_ch;
                            AdcCal  <= w_first_cal;
                            r_cnt   <= C_CAL;
                            r_state <= S_CAL_PULSE;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_CAL_PULSE: begin
                    if (w_cnt_zero) begin
                        AdcCal  <= 2'b00;
                        r_cnt   <= C_WAIT;
                        r_state <= S_WAIT_HI;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_WAIT_HI: begin
                    if (w_busy) begin
                        r_cnt   <= C_TO;
                        r_state <= S_WAIT_LO;
                    end else if (w_cnt_zero) begin
                        error    <= 1'b1;
                        err_code <= CODE_NO_RISE;
                        err_ch   <= r_ch;
                        AdcCal   <= 2'b00;
                        DtuRst_b <= 1'b1;
                        r_cnt    <= C_ZERO;
                        r_state  <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_WAIT_LO: begin
                    if (!w_busy) begin
                        if (w_has_next) begin
                            r_ch    <= 1'b1;
                            AdcCal  <= 2'b10;
                            r_cnt   <= C_CAL;
                            r_state <= S_CAL_PULSE;
                        end else begin
                            r_cnt   <= C_RST;
                            r_state <= S_DTU_HOLD;
                        end
                    end else if (w_cnt_zero) begin
                        error    <= 1'b1;
                        err_code <= CODE_STUCK;
                        err_ch   <= r_ch;
                        AdcCal   <= 2'b00;
                        DtuRst_b <= 1'b1;
                        r_cnt    <= C_ZERO;
                        r_state  <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_DTU_HOLD: begin
                    if (w_cnt_zero) begin
                        DtuRst_b <= 1'b1;
                        DtuFlush <= 1'b1;
                        r_state  <= S_FLUSH;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_FLUSH: begin
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    seq_busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_ERR: begin
                    seq_busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    AdcRst_b <= 2'b11;
                    AdcCal   <= 2'b00;
                    DtuRst_b <= 1'b1;
                    seq_busy <= 1'b0;
                    r_cnt    <= C_ZERO;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// Self-checking bench for adc_cal_sequencer.
// Expected pin timelines are derived arithmetically from the phase lengths of each run.
module tb_adc_cal_sequencer;

    localparam int R  = 16;
    localparam int P  = 4;
    localparam int W  = 64;
    localparam int TO = 4095;
    localparam int NEVER = 100000;
    localparam logic [11:0] IDLE_V = 12'b11_00_1_0_0_0_0_00_0;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cal_mask = 2'b00;
    logic [1:0] busy_in = 2'b00;
    logic [1:0] AdcRst_b;
    logic [1:0] AdcCal;
    logic       DtuRst_b;
    logic       DtuFlush;
    logic       seq_busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic       err_ch;

    int errors = 0;
    int checks = 0;

    adc_cal_sequencer #(
        .RST_CYCLES  (R),
        .CAL_PULSE   (P),
        .BUSY_WAIT   (W),
        .BUSY_TIMEOUT(TO),
        .CNT_W       (12)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cal_mask     (cal_mask),
        .AdcCalBusy_in(busy_in),
        .AdcRst_b     (AdcRst_b),
        .AdcCal       (AdcCal),
        .DtuRst_b     (DtuRst_b),
        .DtuFlush     (DtuFlush),
        .seq_busy     (seq_busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .err_ch       (err_ch)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int k, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp_v);
        end
    endtask

    // One start-to-idle run. cut_k: cycle on which abort (or rst) is driven, -1 for none.
    task automatic run(input string tag, input logic [1:0] m,
                       input int d0, input int w0, input int d1, input int w1,
                       input int cut_k, input bit cut_rst, input int xs_k, input bit ab0);
        int d[2];
        int w[2];
        int ps[2];
        int rise[2];
        int fall[2];
        int t, e, h, errk, code, ech, flushk, donek, idlek, cutk, kend;
        bit err;
        logic [1:0] ar, ac, ec;
        logic dr, fl, sb, dn, er, chb;
        logic [11:0] ev;
        d = '{d0, d1};
        w = '{w0, w1};
        ps = '{-100, -100};
        rise = '{-1, -1};
        fall = '{-1, -1};
        t = R; err = 0; errk = 0; code = 0; ech = 0;
        for (int c = 0; c < 2; c++) begin
            if (m[c] && !err) begin
                ps[c] = t;
                e = t + P;
                rise[c] = e + d[c];
                fall[c] = e + d[c] + w[c];
                if (d[c] + 3 > W) begin
                    err = 1; code = 1; ech = c; errk = e + W;
                end else begin
                    h = e + d[c] + 3;
                    if (w[c] > TO) begin
                        err = 1; code = 2; ech = c; errk = h + TO;
                    end else begin
                        t = h + w[c];
                    end
                end
            end
        end
        flushk = t + R;
        donek = flushk + 1;
        idlek = err ? errk + 1 : donek + 1;
        cutk = (cut_k >= 0) ? cut_k + 1 : (1 << 30);
        kend = ((idlek < cutk) ? idlek : cutk) + 2;

        cal_mask = m;
        start = 1'b1;
        abort = ab0;
        busy_in = 2'b00;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k <= kend; k++) begin
            if (k >= cutk) begin
                ev = IDLE_V;
            end else begin
                ar = (k < R) ? ~m : 2'b11;
                for (int i = 0; i < 2; i++) ac[i] = (k >= ps[i]) && (k < ps[i] + P);
                dr = err ? (k >= errk) : (k >= flushk);
                fl = !err && (k == flushk);
                sb = (k < idlek);
                dn = !err && (k == donek);
                er = err && (k >= errk);
                ec = er ? code[1:0] : 2'b00;
                chb = er ? ech[0] : 1'b0;
                ev = {ar, ac, dr, fl, sb, dn, er, ec, chb};
            end
            chk(tag, k, {AdcRst_b, AdcCal, DtuRst_b, DtuFlush, seq_busy, done, error, err_code, err_ch}, ev);
            for (int c = 0; c < 2; c++) busy_in[c] = m[c] && (k >= rise[c]) && (k < fall[c]);
            abort = (k == cut_k) && !cut_rst;
            rst = (k == cut_k) && cut_rst;
            start = (k == xs_k);
            if (k == xs_k) cal_mask = ~m;
            @(posedge clock); #1;
        end
        busy_in = 2'b00;
        abort = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] rm;
        int rd0, rd1, rw0, rw1;
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_hold", -1, {AdcRst_b, AdcCal, DtuRst_b, DtuFlush, seq_busy, done, error, err_code, err_ch}, IDLE_V);
        rst = 1'b0;
        @(posedge clock); #1;
        chk("reset_idle", -1, {AdcRst_b, AdcCal, DtuRst_b, DtuFlush, seq_busy, done, error, err_code, err_ch}, IDLE_V);

        run("nominal_11", 2'b11, 5, 100, 5, 100, -1, 0, 50, 0);
        run("mask_10", 2'b10, 5, 100, 5, 100, -1, 0, -1, 0);
        run("mask_00_abort_with_start", 2'b00, 0, 1, 0, 1, -1, 0, -1, 1);
        run("busy0_never", 2'b11, NEVER, 1, 5, 10, -1, 0, -1, 0);
        run("rise_edge_ok", 2'b01, 61, 3, 0, 1, -1, 0, -1, 0);
        run("rise_edge_late", 2'b01, 62, 3, 0, 1, -1, 0, -1, 0);
        run("busy1_stuck", 2'b11, 5, 20, 5, NEVER, -1, 0, -1, 0);
        run("clear_after_err", 2'b01, 0, 1, 0, 1, -1, 0, -1, 0);
        run("fall_edge_ok", 2'b10, 0, 1, 2, TO, -1, 0, -1, 0);
        run("abort_wait_lo", 2'b11, 5, 100, 5, 100, 40, 0, -1, 0);
        run("rst_cal_pulse", 2'b11, 5, 100, 5, 100, 17, 1, -1, 0);

        for (int n = 0; n < 8; n++) begin
            rm = 2'($urandom_range(0, 3));
            rd0 = $urandom_range(0, 61);
            rd1 = $urandom_range(0, 61);
            rw0 = $urandom_range(1, 150);
            rw1 = $urandom_range(1, 150);
            if ($urandom_range(0, 3) == 0) rd1 = 62 + $urandom_range(0, 20);
            run("random", rm, rd0, rw0, rd1, rw1, -1, 0, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
